// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M multiply/divide types and constants
// Purpose: funct3 operation encodings, muldiv FSM states and the XLEN constant.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  // DIV and REM are the signed divide ops; funct3 bit 0 clear marks them.
  function automatic logic is_signed_div(input muldiv_op_e op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/rv32m_div_core.sv
// rtl/rv32m_div_core.sv - restoring unsigned divider iterator
// Purpose: one restoring step per cycle on unsigned magnitudes.
// Ports: clk, rst_n (async active-low), load (start new division),
//        a_abs/b_abs (dividend/divisor magnitudes), q/r (quotient/remainder),
//        last (final iteration runs this cycle).
module rv32m_div_core
  import riscv_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int DIV_ITERS_P = DIV_ITERS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [XLEN_P-1:0] a_abs,
  input  logic [XLEN_P-1:0] b_abs,
  output logic [XLEN_P-1:0] q,
  output logic [XLEN_P-1:0] r,
  output logic              last
);

  localparam int CW = $clog2(DIV_ITERS_P);

  logic [XLEN_P-1:0] rem_q, quo_q, dvs_q, rem_next;
  logic [XLEN_P:0]   rem_sh, diff;
  logic [CW-1:0]     cnt_q;
  logic              active_q, ge;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder while quotient bits enter at the LSB.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN_P-1]};
    ge       = rem_sh >= {1'b0, dvs_q};
    diff     = rem_sh - {1'b0, dvs_q};
    rem_next = XLEN_P'(ge ? diff : rem_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= a_abs;
      dvs_q    <= b_abs;
      cnt_q    <= CW'(DIV_ITERS_P - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[XLEN_P-2:0], ge};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign last = active_q && (cnt_q == '0);

endmodule

// File: rtl/rv32m_muldiv.sv
// rtl/rv32m_muldiv.sv - RV32M multiply/divide unit for the EX stage
// Purpose: MUL* in 2 cycles, DIV/REM in 34 (fast paths 2), with flush.
// Ports: clk, rst_n (async active-low), start, op (funct3), A (rs1), B (rs2),
//        flush, busy, done (1-cycle pulse), result (held until next accept).
module rv32m_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int DIV_ITERS_P = DIV_ITERS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN_P-1:0] A,
  input  logic [XLEN_P-1:0] B,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [XLEN_P-1:0] result
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_in, op_q;
  logic [XLEN_P-1:0] a_q, b_q, fast_qv_q, fast_rv_q, result_q;
  logic              q_neg_q, r_neg_q, fast_q;

  logic              accept, sdiv, b_zero, ovf, fast, core_load, core_last;
  logic [XLEN_P-1:0] a_abs, b_abs, core_q, core_r, q_fix, r_fix, div_res, mul_res;
  logic              a_sx, b_sx;
  logic [2*XLEN_P-1:0] prod;

  assign op_in = muldiv_op_e'(op);

  always_comb begin
    sdiv      = is_signed_div(op_in);
    a_abs     = (sdiv && A[XLEN_P-1]) ? -A : A;
    b_abs     = (sdiv && B[XLEN_P-1]) ? -B : B;
    b_zero    = (B == '0);
    ovf       = sdiv && (A == {1'b1, {(XLEN_P-1){1'b0}}}) && (B == '1);
    fast      = b_zero || ovf;
    accept    = (state_q == ST_IDLE) && start && !flush;
    core_load = accept && op_in[2] && !fast;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = !op_in[2] ? ST_MUL : (fast ? ST_FIX : ST_DIV);
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (core_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Sign- or zero-extending both operands to 2*XLEN and keeping the low
  // 2*XLEN product bits gives the same value as a 33x33 signed multiply.
  always_comb begin
    a_sx    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    b_sx    = (op_q == OP_MULH);
    prod    = {{XLEN_P{a_sx & a_q[XLEN_P-1]}}, a_q} * {{XLEN_P{b_sx & b_q[XLEN_P-1]}}, b_q};
    mul_res = (op_q == OP_MUL) ? prod[XLEN_P-1:0] : prod[2*XLEN_P-1:XLEN_P];
    q_fix   = fast_q ? fast_qv_q : (q_neg_q ? -core_q : core_q);
    r_fix   = fast_q ? fast_rv_q : (r_neg_q ? -core_r : core_r);
    div_res = op_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      fast_q    <= 1'b0;
      fast_qv_q <= '0;
      fast_rv_q <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_in;
        a_q       <= A;
        b_q       <= B;
        q_neg_q   <= sdiv && (A[XLEN_P-1] ^ B[XLEN_P-1]);
        r_neg_q   <= sdiv && A[XLEN_P-1];
        fast_q    <= fast;
        fast_qv_q <= b_zero ? '1 : {1'b1, {(XLEN_P-1){1'b0}}};
        fast_rv_q <= b_zero ? A : '0;
      end
      if (!flush && (state_q == ST_MUL)) result_q <= mul_res;
      if (!flush && (state_q == ST_FIX)) result_q <= div_res;
    end
  end

  rv32m_div_core #(
    .XLEN_P      (XLEN_P),
    .DIV_ITERS_P (DIV_ITERS_P)
  ) u_div_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .a_abs (a_abs),
    .b_abs (b_abs),
    .q     (core_q),
    .r     (core_r),
    .last  (core_last)
  );

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb/tb_rv32m_muldiv.sv - directed self-checking bench for rv32m_muldiv
module tb_rv32m_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int lat;
  int dones;

  rv32m_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then count negedges until done (bounded).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    op = o; A = a; B = b; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2);
    run_op("div",    3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34);
    run_op("rem",    3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34);
    run_op("remu",   3'b111, 32'd20,       32'd3,        32'd2,        34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        2);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

    // Flush mid-DIV: result stays 0 from removf, no done pulse.
    op = 3'b101; A = 32'd1000; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_nodone", 32'(dones), 32'd0);
    check("flush_result", result, 32'd0);
    run_op("after_flush", 3'b101, 32'd1000, 32'd9, 32'd111, 34);

    // start held high throughout a DIV: exactly one done.
    op = 3'b100; A = 32'd100; B = 32'd7; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("hold_done_count", 32'(dones), 32'd1);
    check("hold_result", result, 32'd14);

    // Reset pulse mid-DIV clears everything immediately.
    op = 3'b100; A = 32'd77; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
